sum_uart_tx: RTL
================

Name: sum_uart_tx

Overview:
Downstream stage of the 8-bit operand adder. It captures each sum byte through a valid/ready handshake into a small FIFO. Bytes are then serialized as asynchronous 8N1 frames, LSB first, on one output pin, so adder results can be read by an off-chip UART without stalling the producer for short bursts.

Parameters:
CLKS_PER_BIT, 104, clock cycles per serial bit; integer >= 2.
FIFO_DEPTH, 4, FIFO entries; power of two >= 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
sum_in  input  8  sum byte from the adder stage.
sum_valid  input  1  sum_in is valid this cycle.
sum_ready  output  1  FIFO can accept a byte this cycle.
tx  output  1  serial line; idle high.
busy  output  1  serializer is mid-frame.
overflow  output  1  sticky: a byte was offered while the FIFO was full.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low (rst_n); release is synchronized by the top-level.
- Reset values: tx=1, busy=0, sum_ready=1, overflow=0, level=0. FIFO pointers are cleared, state=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame: tx returns to 1 immediately, without waiting for a clock edge. The frame is abandoned and FIFO contents are discarded.
- sum_ready = (level != FIFO_DEPTH). It is derived from registered level only and has no combinational path from sum_valid.
- Push: at a rising edge with sum_valid && sum_ready, sum_in is written at the write pointer and the pointer increments, wrapping modulo FIFO_DEPTH.
- Overflow: at a rising edge with sum_valid && !sum_ready, the byte is dropped and overflow is set. overflow clears only on reset.
- Pop: occurs in IDLE when level != 0, or in the last cycle of STOP when level != 0. The head byte loads the shift register and the read pointer wraps modulo FIFO_DEPTH.
- Push and pop in the same edge: level is unchanged. A push is never accepted at full, even if a pop occurs in the same edge.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1. On pop, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, go to START if a byte was popped, otherwise go to IDLE.
- tx is a register output.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps, and restarts at 0 on every state transition.
- busy = (state != IDLE).
- Latency: for a byte accepted at edge N with the FIFO empty and state IDLE:
  - pop occurs at edge N+1;
  - tx falls at edge N+2;
  - the frame lasts exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.

Optional Feature:
SUM_UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame of 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; 8N1 framing only.

Test Plan:
- Reset: assert rst_n=0 -> tx=1, sum_ready=1, busy=0, level=0, overflow=0 while rst_n is low.
- Single byte, CLKS_PER_BIT=4: push 0xA5 at edge N -> tx falls at N+2. tx then shows 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles. busy drops after 40 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive edges -> two frames totalling 80 cycles, no idle high gap beyond the stop bit, level returns to 0.
- Fill and overflow: hold sum_valid=1 for 6 edges with values 0x01..0x06 from empty -> 0x01..0x05 accepted (0x01 popped at the second edge). sum_ready=0 at the sixth edge, 0x06 dropped, overflow=1. The serial output carries 0x01..0x05 in order.
- Reset mid-frame: assert rst_n during DATA bit 3 of 0x3C -> tx=1 asynchronously, level=0. After release, push 0x81 -> clean frame, no residue of 0x3C.
- Parity (macro defined): push 0x07 -> parity bit 1 and frame 44 cycles at CLKS_PER_BIT=4. Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/sum_uart_tx.sv
// -----------------------------------------------------------------------------
// sum_uart_tx
//
// Purpose: downstream stage of the 8-bit operand adder. Sum bytes are taken in
// through a valid/ready handshake into a small FIFO and serialized as
// asynchronous UART frames (start, 8 data bits LSB first, stop) on tx.
//
// Optional feature: define SUM_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit times).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two >= 2)
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   sum_in     sum byte from the adder stage
//   sum_valid  sum_in is valid this cycle
//   sum_ready  FIFO can accept a byte this cycle (registered level only)
//   tx         serial line, idle high, register output
//   busy       serializer is mid-frame
//   overflow   sticky: a byte was offered while the FIFO was full
//   level      current FIFO occupancy
// -----------------------------------------------------------------------------
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    sum_in,
  input  logic                          sum_valid,
  output logic                          sum_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef SUM_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // FIFO storage is data only: it is never reset, clearing the pointers is
  // enough to discard its contents.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef SUM_UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic [7:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (baud_q == BAUD_LAST);
  assign sum_ready = (level_q != LEVEL_FULL);
  assign push      = sum_valid && sum_ready;
  // A new byte is fetched either from idle or in the final cycle of the stop
  // bit, which is what gives back-to-back frames with no idle gap.
  assign pop       = (level_q != '0) &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (sum_valid && !sum_ready);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sum_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef SUM_UART_TX_PARITY_EN
    parity_d = parity_q;
    if (pop) begin
      parity_d = ^head;
    end
`endif
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = ST_START;
          shift_d = head;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef SUM_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef SUM_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (pop) begin
            state_d = ST_START;
            shift_d = head;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // The line level is registered from the current state, so tx trails the FSM
  // by one cycle: the state leaves IDLE on the pop edge and tx falls one edge
  // later, keeping each bit exactly CLKS_PER_BIT cycles wide on the pin.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef SUM_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
    end
  end

  // Shift register and parity only carry data; they are always loaded on pop
  // before they can reach the line.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef SUM_UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;
  assign level    = level_q;

endmodule
